// File: rtl/fa_nbit_pipe_pkg.sv
// Shared helpers for the fa_nbit adder family: slice sizing and slice index math.
package fa_nbit_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned chunk);
    return k * chunk;
  endfunction

  function automatic int unsigned slice_hi(input int unsigned k, input int unsigned chunk,
                                           input int unsigned width);
    int unsigned hi;
    hi = (k + 1) * chunk - 1;
    return (hi > width - 1) ? width - 1 : hi;
  endfunction

endpackage

// File: rtl/fa_nbit_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface fa_nbit_pipe_if #(
  parameter int unsigned WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov
  );
endinterface

// File: rtl/fa_nbit_pipe_slice.sv
// CHUNK-bit combinational ripple-carry slice used once per pipeline stage.
module fa_nbit_pipe_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    logic c;
    s = '0;
    c = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/fa_nbit_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices, one register per slice,
// valid/ready on both sides with a global stall.
module fa_nbit_pipe
  import fa_nbit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STAGES = 3
) (
  input logic           clk,
  input logic           rst,
  fa_nbit_pipe_if.slave bus
);

  localparam int unsigned CHUNK = ceil_div(WIDTH, STAGES);
  localparam int unsigned PW    = STAGES * CHUNK;

  // Operands are zero-padded to PW bits so every slice is exactly CHUNK wide;
  // the carry out of bit WIDTH-1 then lands in sum bit WIDTH when padding exists.
  typedef struct packed {
    logic          valid;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    logic [PW-1:0] s;
    logic          c;
  } stage_t;

  stage_t           entry;
  stage_t           src  [STAGES];
  stage_t           st_d [STAGES];
  stage_t           st_q [STAGES];
  logic [CHUNK-1:0] sl_s [STAGES];
  logic             sl_co[STAGES];
  logic             stall;
  logic             co_w;

  assign stall = st_q[STAGES-1].valid && !bus.out_ready;

  always_comb begin
    entry       = '0;
    entry.valid = bus.in_valid;
    entry.a     = PW'(bus.a);
    entry.b     = PW'((op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b);
    entry.c     = bus.ci ^ bus.sub;
  end

  always_comb begin
    src[0] = entry;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fa_nbit_pipe_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (src[k].a[slice_lo(k, CHUNK) +: CHUNK]),
      .b  (src[k].b[slice_lo(k, CHUNK) +: CHUNK]),
      .ci (src[k].c),
      .s  (sl_s[k]),
      .co (sl_co[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      st_d[k]                       = src[k];
      st_d[k].s[k*CHUNK +: CHUNK]   = sl_s[k];
      st_d[k].c                     = sl_co[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  if (PW > WIDTH) begin : g_co_pad
    assign co_w = st_q[STAGES-1].s[WIDTH];
  end else begin : g_co_full
    assign co_w = st_q[STAGES-1].c;
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.s         = st_q[STAGES-1].s[WIDTH-1:0];
  assign bus.co        = co_w;
  // Carry into the MSB is recovered as a^b^s at that bit.
  assign bus.ov        = st_q[STAGES-1].a[WIDTH-1] ^ st_q[STAGES-1].b[WIDTH-1]
                       ^ st_q[STAGES-1].s[WIDTH-1] ^ co_w;

endmodule

// File: tb/tb_fa_nbit_pipe.sv
// Scoreboard bench for fa_nbit_pipe: three instances (STAGES=3, 1, WIDTH) share stimulus.
module tb_fa_nbit_pipe;

  localparam int unsigned WIDTH = 12;
  localparam int NDUT = 3;

  typedef struct {
    logic [WIDTH+1:0] res;
    int               cyc;
    int               stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, ci, sub, out_ready;
  logic [WIDTH-1:0] a, b;

  logic             irdy[NDUT], ovld[NDUT], ordy[NDUT], co_o[NDUT], ov_o[NDUT];
  logic [WIDTH-1:0] s_o [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 3 : (g == 1) ? 1 : WIDTH;
    fa_nbit_pipe_if #(.WIDTH(WIDTH)) bus ();
    fa_nbit_pipe #(.WIDTH(WIDTH), .STAGES(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.ci        = ci;
    assign bus.sub       = sub;
    assign bus.out_ready = (g == 0) ? out_ready : 1'b1;
    assign irdy[g]       = bus.in_ready;
    assign ovld[g]       = bus.out_valid;
    assign ordy[g]       = bus.out_ready;
    assign s_o[g]        = bus.s;
    assign co_o[g]       = bus.co;
    assign ov_o[g]       = bus.ov;
  end

  function automatic int st_of(input int g);
    return (g == 0) ? 3 : (g == 1) ? 1 : int'(WIDTH);
  endfunction

  // Reference: plain integer arithmetic on the add/subtract rules.
  function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic c, input logic sb);
    longint m, ux, uy, sx, sy, r, sr;
    logic co_e, ov_e;
    logic [WIDTH-1:0] s_e;
    m  = longint'(1) << WIDTH;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[WIDTH-1] ? ux - m : ux;
    sy = y[WIDTH-1] ? uy - m : uy;
    if (!sb) begin
      r    = ux + uy + longint'(c);
      sr   = sx + sy + longint'(c);
      co_e = (r >= m);
    end else begin
      r    = ux - uy - longint'(c);
      sr   = sx - sy - longint'(c);
      co_e = (r >= 0);
    end
    ov_e = (sr < -(m / 2)) || (sr >= m / 2);
    r    = ((r % m) + m) % m;
    s_e  = r[WIDTH-1:0];
    return {co_e, ov_e, s_e};
  endfunction

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   stalls[NDUT];
  exp_t sbq[NDUT][$];
  logic             dir_en = 1'b0;
  logic [WIDTH+1:0] dir_exp = '0;
  logic             chk_reset = 1'b0;
  logic             final_chk = 1'b0;

  task automatic check(input string name, input int g, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut=%0d cycle=%0d actual=%0h required=%0h", name, g, cyc, act, req);
    end
  endtask

  initial for (int g = 0; g < NDUT; g++) stalls[g] = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    for (int g = 0; g < NDUT; g++) begin
      if (rst) begin
        sbq[g].delete();
      end else begin
        if (ovld[g] && ordy[g]) begin
          if (sbq[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output dut=%0d cycle=%0d actual=%0h required=none",
                     g, cyc, {co_o[g], ov_o[g], s_o[g]});
          end else begin
            e = sbq[g].pop_front();
            check("result", g, longint'({co_o[g], ov_o[g], s_o[g]}), longint'(e.res));
            check("latency", g, cyc, e.cyc + st_of(g) + stalls[g] - e.stl);
          end
        end
        check("in_ready", g, longint'(irdy[g]), longint'(!(ovld[g] && !ordy[g])));
        if (ovld[g] && !ordy[g]) stalls[g]++;
        if (in_valid && irdy[g])
          sbq[g].push_back('{dir_en ? dir_exp : ref_model(a, b, ci, sub), cyc, stalls[g]});
      end
      if (chk_reset) begin
        check("rst_out_valid", g, longint'(ovld[g]), 0);
        check("rst_outputs", g, longint'({co_o[g], ov_o[g], s_o[g]}), 0);
        check("rst_in_ready", g, longint'(irdy[g]), 1);
      end
      if (final_chk) check("drain", g, sbq[g].size(), 0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xci, input logic xsub, input logic de,
                       input logic [WIDTH+1:0] dv);
    in_valid = 1'b1;
    a = xa; b = xb; ci = xci; sub = xsub;
    dir_en = de; dir_exp = dv;
    next_cycle();
    in_valid = 1'b0;
    dir_en = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic drive_rand();
    drive(pick_op(), pick_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  initial begin : stim
    int pending;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_reset = 1'b1;
    next_cycle();
    chk_reset = 1'b0;

    // directed arithmetic cases, back-to-back
    drive(12'd100,  12'd200, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 12'd301});
    drive(12'hFFF,  12'd1,   1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 12'h000});
    drive(12'h7FF,  12'd1,   1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 12'h800});
    drive(12'd5,    12'd7,   1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 12'hFFE});
    drive(12'd7,    12'd5,   1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 12'h002});
    idle(5);

    repeat (10) drive_rand();
    idle(2);

    // stream with a 4-cycle consumer stall in the middle
    for (int i = 0; i < 20; i++) begin
      if (i == 6)  out_ready = 1'b0;
      if (i == 10) out_ready = 1'b1;
      drive_rand();
    end
    idle(4);

    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7) drive_rand();
      else idle(1);
    end
    out_ready = 1'b1;
    idle(6);

    // reset with operands in flight
    drive_rand();
    drive_rand();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; chk_reset = 1'b1;
    next_cycle();
    chk_reset = 1'b0;
    idle(5);
    drive(12'd100, 12'd200, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 12'd301});

    pending = 1;
    for (int i = 0; i < 100 && pending != 0; i++) begin
      pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
      next_cycle();
    end
    final_chk = 1'b1;
    next_cycle();
    final_chk = 1'b0;
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
